noise_power_estimator: RTL and testbench
========================================

Name: noise_power_estimator

Overview:
- Receive-side counterpart of the channel noise source: measures the noise that the channel actually added.
- Takes equalised received I/Q plus the slicer's decided ideal constellation point per symbol.
- Accumulates error energy over fixed windows; outputs mean error energy and per-component RMS error (Q1.11 magnitude) once per window.
- Sits after the slicer; feeds the SNR/BER display and the noise_magnitude calibration loop.

Parameters:
- LOG2_WIN, 10, log2 of symbols per window; legal range 4..16.
- SQRT_W, 12, RMS result width; fixed by DATA_WIDTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: restart window, abort sqrt
- in_valid  in  1  symbol qualifier; no backpressure
- rx_i, rx_q  in  12 each  received sample_t, Q1.11
- ref_i, ref_q  in  12 each  decided ideal point, sample_t, Q1.11
- err_pow  out  26  mean per-symbol error energy, e_i²+e_q², LSB = 2^-22
- err_rms  out  12  unsigned RMS error per component, LSB = 2^-11
- est_valid  out  1  one-cycle pulse when err_pow/err_rms update
- busy  out  1  sqrt in progress

Behaviour:
- Reset: err_pow=0, err_rms=0, est_valid=0, busy=0; counter, accumulator, pipeline cleared.
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Stage S1, registered on in_valid:
  - e_i = rx_i − ref_i, 13-bit signed; same for e_q.
  - sq = e_i² + e_q², 26-bit unsigned; max 2·4095² = 33,538,050.
- Stage S2: acc += sq; acc is (26+LOG2_WIN) bits, cannot overflow; sym_cnt increments.
- Window end:
  - On the 2^LOG2_WIN-th accumulated symbol: snapshot mean = acc >> LOG2_WIN into err_pow_next.
  - Same cycle: acc and sym_cnt reset to zero, so the next symbol is in the new window. No symbol dropped or double counted.
- FSM:
  - IDLE → SQRT on snapshot.
  - SQRT: 12-iteration bit-serial restoring square root of (mean >> 1), one result bit per cycle, MSB first.
  - SQRT → DONE after 12 cycles.
  - DONE, one cycle: load err_pow and err_rms together, pulse est_valid → IDLE.
  - busy is high in SQRT and DONE.
- err_rms = floor(sqrt(mean/2)); 24-bit radicand gives ≤ 4095, so no saturation is needed.
- Latency: est_valid asserts exactly 15 cycles after the edge that samples the window's last in_valid (S1 +1, S2 +1, snapshot/SQRT 12, DONE +1).
- Accumulation runs in parallel with SQRT. Minimum window of 16 symbols exceeds the 14-cycle sqrt span, so back-to-back windows never collide.
- in_valid gaps are allowed: counts advance only on valid symbols; the pipeline advances only on valid symbols.
- clear:
  - Zeroes acc, sym_cnt and pipeline valids; FSM → IDLE.
  - No est_valid for the aborted window; err_pow/err_rms hold their last values.
  - clear and in_valid in the same cycle: clear wins and that symbol is discarded.
- Outputs change only in DONE; they are stable otherwise.

Optional Feature:
- Macro NOISE_EST_PEAK_EN.
- Defined:
  - Adds output err_peak [25:0], the maximum sq seen in the window.
  - Updated together with err_pow in DONE; reset 0; peak tracker cleared at window start and by clear.
- Undefined: port and logic absent; everything else identical.

Decomposition:
- gdsp_pkg additions:
  - NOISE_EST_ERR_W=13, NOISE_EST_SQ_W=26, NOISE_EST_RMS_W=12.
  - Localparam-derived accumulator width.
  - est_state_t enum {EST_IDLE, EST_SQRT, EST_DONE}.
- One sub-module, isqrt_serial:
  - Parameterised radicand width, start/done handshake, 1 bit/cycle.
  - Reusable by the future EVM block.

Test Plan:
- rx == ref for 1024 symbols → err_pow=0, err_rms=0, est_valid pulse at cycle last+15.
- Constant error e_i=e_q=+16 LSB for 1024 symbols → err_pow=512, err_rms=16.
- rx=+2047, ref=−2048 on both rails, full window → err_pow=33,538,050, err_rms=4095, no wrap.
- Window split by random in_valid gaps, alternating e_i=±32, e_q=0 → err_pow=1024, err_rms=22; est_valid exactly once per 1024 valid symbols.
- clear asserted at symbol 500 of window 2 → no est_valid for that window; outputs hold window-1 values; next est_valid 1024 valid symbols after clear deasserts.
- NOISE_EST_PEAK_EN defined, one symbol with e_i=100, e_q=0 among zero-error symbols → err_peak=10000; rst_n pulsed mid-SQRT → all outputs 0, busy=0 immediately.

Source files
------------

// File: rtl/noise_power_estimator_pkg.sv
// Shared types, widths and helpers for the receive-side noise power estimator.
// Optional peak tracking in the top is enabled by defining NOISE_EST_PEAK_EN.
package noise_power_estimator_pkg;

    localparam int NOISE_EST_IN_W  = 12;
    localparam int NOISE_EST_ERR_W = 13;
    localparam int NOISE_EST_SQ_W  = 26;
    localparam int NOISE_EST_RMS_W = 12;

    typedef enum logic [1:0] {
        EST_IDLE = 2'd0,
        EST_SQRT = 2'd1,
        EST_DONE = 2'd2
    } est_state_t;

    // The accumulator holds 2^log2_win squared errors without overflow.
    function automatic int noise_est_acc_w(input int log2_win);
        return NOISE_EST_SQ_W + log2_win;
    endfunction

    // Per-symbol error energy e_i^2 + e_q^2 of two Q1.11 points.
    function automatic logic [NOISE_EST_SQ_W-1:0] noise_est_sq(
        input logic [NOISE_EST_IN_W-1:0] rx_i,
        input logic [NOISE_EST_IN_W-1:0] ref_i,
        input logic [NOISE_EST_IN_W-1:0] rx_q,
        input logic [NOISE_EST_IN_W-1:0] ref_q
    );
        logic signed [NOISE_EST_ERR_W-1:0] e_i;
        logic signed [NOISE_EST_ERR_W-1:0] e_q;
        logic signed [NOISE_EST_SQ_W-1:0]  p_i;
        logic signed [NOISE_EST_SQ_W-1:0]  p_q;
        e_i = $signed({rx_i[NOISE_EST_IN_W-1], rx_i}) - $signed({ref_i[NOISE_EST_IN_W-1], ref_i});
        e_q = $signed({rx_q[NOISE_EST_IN_W-1], rx_q}) - $signed({ref_q[NOISE_EST_IN_W-1], ref_q});
        p_i = e_i * e_i;
        p_q = e_q * e_q;
        return $unsigned(p_i) + $unsigned(p_q);
    endfunction

endpackage

// File: rtl/noise_power_estimator_isqrt_serial.sv
// Bit-serial restoring integer square root, one result bit per cycle, MSB first.
// Pulse start with the radicand; done pulses for one cycle when root is final.
module isqrt_serial #(
    parameter int RAD_W  = 24,
    parameter int ROOT_W = RAD_W / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [RAD_W-1:0]  radicand,
    output logic              done,
    output logic [ROOT_W-1:0] root
);

    localparam int CNT_W = $clog2(ROOT_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

    logic [RAD_W-1:0]  rad_d, rad_q;
    logic [ROOT_W+1:0] rem_d, rem_q;
    logic [ROOT_W-1:0] root_d, root_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              run_d, run_q;
    logic              done_d, done_q;
    logic [ROOT_W+1:0] rem_shift_s;
    logic [ROOT_W+1:0] trial_s;

    // One restoring iteration: bring down two radicand bits, try 4*root+1.
    always_comb begin
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        done_d      = 1'b0;
        rem_shift_s = (rem_q << 2) | {{ROOT_W{1'b0}}, rad_q[RAD_W-1 -: 2]};
        trial_s     = {root_q, 2'b01};
        if (clear) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            rad_d  = radicand;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (rem_shift_s >= trial_s) begin
                rem_d  = rem_shift_s - trial_s;
                root_d = {root_q[ROOT_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_shift_s;
                root_d = {root_q[ROOT_W-2:0], 1'b0};
            end
            rad_d = {rad_q[RAD_W-3:0], 2'b00};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/noise_power_estimator.sv
// Windowed error-energy estimator: mean e_i^2+e_q^2 and per-component RMS per window.
// Define NOISE_EST_PEAK_EN to add err_peak, the largest per-symbol energy of the window.
module noise_power_estimator
    import noise_power_estimator_pkg::*;
#(
    parameter int LOG2_WIN = 10,
    parameter int SQRT_W   = NOISE_EST_RMS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [NOISE_EST_IN_W-1:0] rx_i,
    input  logic [NOISE_EST_IN_W-1:0] rx_q,
    input  logic [NOISE_EST_IN_W-1:0] ref_i,
    input  logic [NOISE_EST_IN_W-1:0] ref_q,
    output logic [NOISE_EST_SQ_W-1:0] err_pow,
    output logic [SQRT_W-1:0]         err_rms,
`ifdef NOISE_EST_PEAK_EN
    output logic [NOISE_EST_SQ_W-1:0] err_peak,
`endif
    output logic                      est_valid,
    output logic                      busy
);

    localparam int ACC_W = noise_est_acc_w(LOG2_WIN);
    localparam logic [LOG2_WIN-1:0] CNT_ONE = LOG2_WIN'(1);

    logic [NOISE_EST_SQ_W-1:0] sq_d, sq_q;
    logic                      s1_vld_d, s1_vld_q;
    logic [ACC_W-1:0]          acc_d, acc_q, acc_sum_s;
    logic [LOG2_WIN-1:0]       cnt_d, cnt_q;
    logic                      win_end_s;
    logic [NOISE_EST_SQ_W-1:0] mean_s;
    logic [NOISE_EST_SQ_W-1:0] snap_d, snap_q;
    logic [2*SQRT_W-1:0]       radicand_s;
    logic [SQRT_W-1:0]         root_s;
    logic                      sqrt_start_s, sqrt_done_s;
    est_state_t                state_d, state_q;
    logic [NOISE_EST_SQ_W-1:0] err_pow_d, err_pow_q;
    logic [SQRT_W-1:0]         err_rms_d, err_rms_q;
    logic                      est_valid_d, est_valid_q;
    logic                      busy_d, busy_q;

    // S1: register the symbol's error energy; clear discards a coincident symbol.
    always_comb begin
        s1_vld_d = in_valid & ~clear;
        if (in_valid) begin
            sq_d = noise_est_sq(rx_i, ref_i, rx_q, ref_q);
        end else begin
            sq_d = sq_q;
        end
    end

    // S2: accumulate; the last symbol of a window restarts acc/count in the same cycle.
    always_comb begin
        acc_sum_s = acc_q + {{LOG2_WIN{1'b0}}, sq_q};
        mean_s    = acc_sum_s[LOG2_WIN +: NOISE_EST_SQ_W];
        win_end_s = s1_vld_q & (&cnt_q) & ~clear;
        if (clear || win_end_s) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (s1_vld_q) begin
            acc_d = acc_sum_s;
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // RMS per component is sqrt(mean/2); mean/2 never exceeds 4095^2.
    assign radicand_s = mean_s[2*SQRT_W:1];

    // Control: snapshot on window end, wait for the root, publish in DONE.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        sqrt_start_s = 1'b0;
        if (clear) begin
            state_d = EST_IDLE;
        end else begin
            case (state_q)
                EST_IDLE: begin
                    if (win_end_s) begin
                        state_d      = EST_SQRT;
                        snap_d       = mean_s;
                        sqrt_start_s = 1'b1;
                    end else begin
                        state_d = EST_IDLE;
                    end
                end
                EST_SQRT: begin
                    if (sqrt_done_s) begin
                        state_d = EST_DONE;
                    end else begin
                        state_d = EST_SQRT;
                    end
                end
                EST_DONE: state_d = EST_IDLE;
                default:  state_d = EST_IDLE;
            endcase
        end
        est_valid_d = (state_q == EST_DONE) & ~clear;
        if (est_valid_d) begin
            err_pow_d = snap_q;
            err_rms_d = root_s;
        end else begin
            err_pow_d = err_pow_q;
            err_rms_d = err_rms_q;
        end
        busy_d = (state_d != EST_IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_q     <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            snap_q   <= '0;
        end else begin
            sq_q     <= sq_d;
            s1_vld_q <= s1_vld_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EST_IDLE;
            err_pow_q   <= '0;
            err_rms_q   <= '0;
            est_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_pow_q   <= err_pow_d;
            err_rms_q   <= err_rms_d;
            est_valid_q <= est_valid_d;
            busy_q      <= busy_d;
        end
    end

    isqrt_serial #(
        .RAD_W (2*SQRT_W),
        .ROOT_W(SQRT_W)
    ) u_isqrt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .start   (sqrt_start_s),
        .radicand(radicand_s),
        .done    (sqrt_done_s),
        .root    (root_s)
    );

    assign err_pow   = err_pow_q;
    assign err_rms   = err_rms_q;
    assign est_valid = est_valid_q;
    assign busy      = busy_q;

`ifdef NOISE_EST_PEAK_EN
    logic [NOISE_EST_SQ_W-1:0] peak_cand_s;
    logic [NOISE_EST_SQ_W-1:0] peak_run_d, peak_run_q;
    logic [NOISE_EST_SQ_W-1:0] peak_snap_d, peak_snap_q;
    logic [NOISE_EST_SQ_W-1:0] err_peak_d, err_peak_q;

    // Running maximum, restarted at each window boundary like the accumulator.
    always_comb begin
        peak_cand_s = (sq_q > peak_run_q) ? sq_q : peak_run_q;
        if (clear || win_end_s) begin
            peak_run_d = '0;
        end else if (s1_vld_q) begin
            peak_run_d = peak_cand_s;
        end else begin
            peak_run_d = peak_run_q;
        end
        if (sqrt_start_s) begin
            peak_snap_d = peak_cand_s;
        end else begin
            peak_snap_d = peak_snap_q;
        end
        if (est_valid_d) begin
            err_peak_d = peak_snap_q;
        end else begin
            err_peak_d = err_peak_q;
        end
    end

    // Peak tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_run_q  <= '0;
            peak_snap_q <= '0;
            err_peak_q  <= '0;
        end else begin
            peak_run_q  <= peak_run_d;
            peak_snap_q <= peak_snap_d;
            err_peak_q  <= err_peak_d;
        end
    end

    assign err_peak = err_peak_q;
`endif

endmodule

// File: tb/tb_noise_power_estimator.sv
// Randomised scoreboard bench for noise_power_estimator (window of 1024 symbols).
module tb_noise_power_estimator;

    localparam int WIN = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] rx_i = 12'd0, rx_q = 12'd0, ref_i = 12'd0, ref_q = 12'd0;
    logic [25:0] err_pow;
    logic [11:0] err_rms;
    logic        est_valid;
    logic        busy;
`ifdef NOISE_EST_PEAK_EN
    logic [25:0] err_peak;
`endif

    noise_power_estimator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .rx_i     (rx_i),
        .rx_q     (rx_q),
        .ref_i    (ref_i),
        .ref_q    (ref_q),
        .err_pow  (err_pow),
        .err_rms  (err_rms),
`ifdef NOISE_EST_PEAK_EN
        .err_peak (err_peak),
`endif
        .est_valid(est_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint pow;
        longint rms;
        longint peak;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    longint m_peak = 0;
    longint held_pow = 0, held_rms = 0, held_peak = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint isqrt_ref(input longint x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Drive one valid symbol and update the reference window model.
    task automatic send(input logic [11:0] ri, input logic [11:0] rq,
                        input logic [11:0] fi, input logic [11:0] fq);
        int     ei, eq;
        longint sq;
        exp_t   e;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b1;
        rx_i = ri; rx_q = rq; ref_i = fi; ref_q = fq;
        ei = int'($signed(ri)) - int'($signed(fi));
        eq = int'($signed(rq)) - int'($signed(fq));
        sq = longint'(ei) * ei + longint'(eq) * eq;
        m_sum += sq;
        m_cnt++;
        if (sq > m_peak) m_peak = sq;
        if (m_cnt == WIN) begin
            e.pow  = m_sum / WIN;
            e.rms  = isqrt_ref(e.pow / 2);
            e.peak = m_peak;
            e.cyc  = cyc + 1 + 15;
            sb.push_back(e);
            m_sum = 0; m_cnt = 0; m_peak = 0;
        end
    endtask

    task automatic send_err(input int ei, input int eq);
        int ri, rq;
        ri = int'($urandom_range(0, 3800)) - 1900;
        rq = int'($urandom_range(0, 3800)) - 1900;
        send(12'(ri + ei), 12'(rq + eq), 12'(ri), 12'(rq));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear = 1'b0;
        end
    endtask

    // Monitor: pop and compare on every est_valid, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (est_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_est_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("err_pow", longint'(err_pow), mon_e.pow);
                    check("err_rms", longint'(err_rms), mon_e.rms);
                    check("latency", cyc, mon_e.cyc);
`ifdef NOISE_EST_PEAK_EN
                    check("err_peak", longint'(err_peak), mon_e.peak);
                    held_peak = mon_e.peak;
`endif
                    held_pow = mon_e.pow;
                    held_rms = mon_e.rms;
                end
            end else begin
                check("hold_pow", longint'(err_pow), held_pow);
                check("hold_rms", longint'(err_rms), held_rms);
`ifdef NOISE_EST_PEAK_EN
                check("hold_peak", longint'(err_peak), held_peak);
`endif
            end
        end
    end

    initial begin
        int pk;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pow", longint'(err_pow), 0);
        check("rst_rms", longint'(err_rms), 0);
        check("rst_valid", longint'(est_valid), 0);
        check("rst_busy", longint'(busy), 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // rx == ref
        for (int i = 0; i < WIN; i++) begin
            logic [11:0] a, b;
            a = 12'($urandom); b = 12'($urandom);
            send(a, b, a, b);
        end
        // constant +16 error on both rails
        for (int i = 0; i < WIN; i++) send_err(16, 16);
        idle(3);
        // full-scale error
        for (int i = 0; i < WIN; i++) send(12'h7FF, 12'h7FF, 12'h800, 12'h800);
        idle(20);
        // alternating +-32 with random gaps
        for (int i = 0; i < WIN; i++) begin
            send_err((i % 2 == 0) ? 32 : -32, 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        // one large error among zero-error symbols
        pk = int'($urandom_range(0, WIN - 1));
        for (int i = 0; i < WIN; i++) send_err((i == pk) ? 100 : 0, 0);
        idle(20);
        // abort part of a window; clear coincides with a valid symbol
        for (int i = 0; i < 500; i++) send(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
        idle(2);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1;
        rx_i = 12'h7FF; rx_q = 12'h7FF; ref_i = 12'h800; ref_q = 12'h800;
        m_sum = 0; m_cnt = 0; m_peak = 0;
        idle(2);
        for (int i = 0; i < WIN; i++) begin
            send(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(20);
        // reset in the middle of the square root
        for (int i = 0; i < WIN; i++) send_err(int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
        idle(6);
        @(posedge clk); #1;
        check("busy_mid_sqrt", longint'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pow", longint'(err_pow), 0);
        check("arst_rms", longint'(err_rms), 0);
        check("arst_valid", longint'(est_valid), 0);
        check("arst_busy", longint'(busy), 0);
`ifdef NOISE_EST_PEAK_EN
        check("arst_peak", longint'(err_peak), 0);
`endif
        sb.delete();
        held_pow = 0; held_rms = 0; held_peak = 0;
        m_sum = 0; m_cnt = 0; m_peak = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        // recovery window with random errors
        for (int i = 0; i < WIN; i++) send_err(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300);
        idle(30);
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
